// File: rtl/basic_spi_ctrl.sv
// SPI transfer sequencer: drives SCLK/SS_N and the shift-datapath strobes, one transfer per start.
// Optional SPI_MODE_SEL_EN adds cpol/cpha inputs; without it the block runs fixed mode 0.
module basic_spi_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
`ifdef SPI_MODE_SEL_EN
  input  logic cpol,
  input  logic cpha,
`endif
  output logic sclk,
  output logic ss_n,
  output logic i_load,
  output logic i_en,
  output logic miso_le,
  output logic tbuf_mosi_oe,
  output logic done,
  output logic busy
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned BitW = $clog2(WIDTH);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSetup, StLead, StTrail, StDone} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic            cpol_q, cpha_q;
  logic            div_last, div_first;

  logic sclk_d, ss_n_d, i_load_d, i_en_d, miso_le_d, oe_d, done_d, busy_d;

  assign div_last  = (div_cnt_q == DivLast);
  assign div_first = (div_cnt_q == '0);

`ifdef SPI_MODE_SEL_EN
  // Captured on the edge that enters LOAD so the whole transfer, LOAD included, sees one mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      cpol_q <= cpol;
      cpha_q <= cpha;
    end
  end
`else
  assign cpol_q = 1'b0;
  assign cpha_q = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StSetup;
      StSetup: if (div_last) state_d = StLead;
      StLead:  if (div_last) state_d = StTrail;
      StTrail: if (div_last) state_d = (bit_cnt_q == BitLast) ? StDone : StLead;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    div_cnt_d = div_cnt_q + DivW'(1);
    if (state_q == StIdle || state_d != state_q) div_cnt_d = '0;
    bit_cnt_d = bit_cnt_q;
    if (state_q == StIdle) begin
      bit_cnt_d = '0;
    end else if (state_q == StTrail && div_last) begin
      bit_cnt_d = bit_cnt_q + BitW'(1);
    end
  end

  // Outputs are a registered decode of the current state, so pins trail the state by one cycle.
  always_comb begin
    sclk_d    = cpol_q;
    ss_n_d    = 1'b0;
    i_load_d  = 1'b0;
    i_en_d    = 1'b0;
    miso_le_d = 1'b0;
    oe_d      = 1'b0;
    done_d    = 1'b0;
    busy_d    = 1'b0;
    unique case (state_q)
      StIdle: ss_n_d = 1'b1;
      StLoad: begin
        ss_n_d   = 1'b1;
        i_load_d = 1'b1;
        i_en_d   = 1'b1;
        busy_d   = 1'b1;
      end
      StSetup: begin
        oe_d   = 1'b1;
        busy_d = 1'b1;
      end
      StLead: begin
        sclk_d    = ~cpol_q;
        oe_d      = 1'b1;
        busy_d    = 1'b1;
        miso_le_d = ~cpha_q & div_first;
      end
      StTrail: begin
        oe_d      = 1'b1;
        busy_d    = 1'b1;
        miso_le_d = cpha_q & div_first;
        i_en_d    = cpha_q ? div_last : div_first;
      end
      StDone: begin
        oe_d   = 1'b1;
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ss_n_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk         <= 1'b0;
      ss_n         <= 1'b1;
      i_load       <= 1'b0;
      i_en         <= 1'b0;
      miso_le      <= 1'b0;
      tbuf_mosi_oe <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sclk         <= sclk_d;
      ss_n         <= ss_n_d;
      i_load       <= i_load_d;
      i_en         <= i_en_d;
      miso_le      <= miso_le_d;
      tbuf_mosi_oe <= oe_d;
      done         <= done_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_basic_spi_ctrl.sv
// Self-checking bench for basic_spi_ctrl: cycle-indexed timing model, bench-side shift datapath,
// table of transfers, hand-written corner sequences and a randomized run.
module tb_basic_spi_ctrl;

  localparam int W     = 16;
  localparam int H     = 4;
  localparam int DoneU = 1 + H + 2 * H * W;  // state-cycle index of DONE after the start edge
`ifdef SPI_MODE_SEL_EN
  localparam bit ModeSel = 1'b1;
`else
  localparam bit ModeSel = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, cpol, cpha;
  logic sclk, ss_n, i_load, i_en, miso_le, tbuf_mosi_oe, done, busy;

  always #5 clk = ~clk;

  basic_spi_ctrl #(.WIDTH(W), .CLK_DIV(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
`ifdef SPI_MODE_SEL_EN
    .cpol         (cpol),
    .cpha         (cpha),
`endif
    .sclk         (sclk),
    .ss_n         (ss_n),
    .i_load       (i_load),
    .i_en         (i_en),
    .miso_le      (miso_le),
    .tbuf_mosi_oe (tbuf_mosi_oe),
    .done         (done),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference: index of the controller's current state cycle since its start edge, -1 when idle.
  int st_u  = -1;
  bit pol_m = 1'b0;
  bit pha_m = 1'b0;

  // Bench-side datapath and slave.
  logic [15:0] tx_word, slave_word, sr, rx_buf, mosi_word;
  logic        miso_ff, sclk_prev;
  bit          loopback;
  int          le_k, en_cnt, load_cnt, le_cnt, done_cnt, last_le;

  typedef struct {
    logic [15:0] tx;
    logic [15:0] slave;
    bit          lb;
    bit          pol;
    bit          pha;
    logic [15:0] exp_rx;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected {sclk, ss_n, i_load, i_en, miso_le, oe, done, busy} for state-cycle index u.
  function automatic logic [7:0] expect_out(int u, bit pol, bit pha);
    logic s, sn, ld, en, le, oe, dn, bz;
    int   p, ph, off;
    bit   lead;
    s = pol; sn = 1'b1; ld = 1'b0; en = 1'b0; le = 1'b0; oe = 1'b0; dn = 1'b0; bz = 1'b0;
    if (u == 0) begin
      ld = 1'b1; en = 1'b1; bz = 1'b1;
    end else if (u >= 1 && u <= DoneU) begin
      sn = 1'b0; oe = 1'b1; bz = 1'b1;
      if (u == DoneU) begin
        dn = 1'b1;
      end else if (u > H) begin
        p    = u - 1 - H;
        ph   = p % (2 * H);
        lead = (ph < H);
        off  = ph % H;
        if (lead) s = ~pol;
        if (pha) begin
          le = !lead && off == 0;
          en = !lead && off == H - 1;
        end else begin
          le = lead && off == 0;
          en = !lead && off == 0;
        end
      end
    end
    return {s, sn, ld, en, le, oe, dn, bz};
  endfunction

  // One clock: compare outputs to the model, advance the model, run the datapath on the strobes.
  task automatic step();
    logic       start_s, rst_s, cpol_s, cpha_s;
    logic [7:0] exp_v;
    start_s = start; rst_s = rst; cpol_s = cpol; cpha_s = cpha;
    @(posedge clk);
    #1;
    cyc++;
    exp_v = rst_s ? 8'b0100_0000 : expect_out(st_u, pol_m, pha_m);
    check("outputs", {sclk, ss_n, i_load, i_en, miso_le, tbuf_mosi_oe, done, busy}, exp_v);
    if (rst_s) begin
      st_u = -1; pol_m = 1'b0; pha_m = 1'b0;
    end else if (st_u < 0) begin
      if (start_s) begin
        st_u  = 0;
        pol_m = ModeSel & cpol_s;
        pha_m = ModeSel & cpha_s;
      end
    end else if (st_u == DoneU) begin
      st_u = -1;
    end else begin
      st_u++;
    end
    if (miso_le) begin
      miso_ff   = loopback ? sr[15] : slave_word[15 - (le_k % 16)];
      mosi_word = {mosi_word[14:0], sr[15]};
      check("le_on_sclk_edge", {30'd0, sclk_prev, sclk},
            pha_m ? {30'd0, ~pol_m, pol_m} : {30'd0, pol_m, ~pol_m});
      le_k++; le_cnt++; last_le = cyc;
    end
    if (i_en && i_load) begin
      sr = tx_word; load_cnt++;
    end else if (i_en) begin
      sr = {sr[14:0], miso_ff}; en_cnt++;
      check("le_to_shift_gap", cyc - last_le, pha_m ? H - 1 : H);
    end
    if (done) begin
      rx_buf = sr; done_cnt++;
    end
    sclk_prev = sclk;
  endtask

  task automatic clear_counts();
    le_k = 0; en_cnt = 0; load_cnt = 0; le_cnt = 0; done_cnt = 0; mosi_word = '0;
  endtask

  task automatic run_xfer(input vec_t v, output int done_at);
    tx_word = v.tx; slave_word = v.slave; loopback = v.lb; cpol = v.pol; cpha = v.pha;
    clear_counts();
    start = 1'b1;
    step();
    start = 1'b0;
    done_at = -1;
    for (int n = 1; n < 300 && done_at < 0; n++) begin
      step();
      if (done) done_at = n;
    end
    step();
    step();
  endtask

  initial begin
    int done_at, d1, d2, hi;
    bit between;
    rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; loopback = 1'b0;
    tx_word = '0; slave_word = '0; sr = '0; rx_buf = '0; miso_ff = 1'b0; sclk_prev = 1'b0;
    last_le = -1000;
    clear_counts();
    step();
    step();
    check("reset_ss_n", ss_n, 1'b1);
    check("reset_sclk", sclk, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b0;
    step();

    vecs.push_back('{16'hA53C, 16'h3CA5, 1'b0, 1'b0, 1'b0, 16'h3CA5});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'hFFFF});
    vecs.push_back('{16'h8001, 16'h7FFE, 1'b0, 1'b0, 1'b0, 16'h7FFE});
    vecs.push_back('{16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b0, 16'h1234});
`ifdef SPI_MODE_SEL_EN
    vecs.push_back('{16'hFFFF, 16'h1111, 1'b1, 1'b1, 1'b1, 16'hFFFF});
    vecs.push_back('{16'h0000, 16'h2222, 1'b1, 1'b1, 1'b1, 16'h0000});
    vecs.push_back('{16'hC3A5, 16'h5A3C, 1'b0, 1'b1, 1'b0, 16'h5A3C});
    vecs.push_back('{16'h6B1D, 16'h9E07, 1'b0, 1'b0, 1'b1, 16'h9E07});
`endif
    foreach (vecs[i]) begin
      run_xfer(vecs[i], done_at);
      check("done_cycle", done_at, DoneU + 1);
      check("rx_buf", rx_buf, vecs[i].exp_rx);
      check("mosi_bits", mosi_word, vecs[i].tx);
      check("shift_pulses", en_cnt, W);
      check("load_pulses", load_cnt, 1);
      check("miso_le_pulses", le_cnt, W);
      check("done_pulses", done_cnt, 1);
      check("idle_sclk", sclk, vecs[i].pol);
      check("idle_ss_n", ss_n, 1'b1);
    end

    // Reset during bit 5: outputs return to reset values and no done follows.
    cpol = 1'b0; cpha = 1'b0; loopback = 1'b0;
    clear_counts();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n < 1 + H + 5 * 2 * H + 2; n++) step();
    rst = 1'b1;
    step();
    check("midrst_ss_n", ss_n, 1'b1);
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_busy", busy, 1'b0);
    step();
    rst = 1'b0;
    for (int n = 0; n < 200; n++) step();
    check("midrst_no_done", done_cnt, 0);

    // Start pulses while busy are dropped.
    clear_counts();
    start = 1'b1;
    step();
    for (int n = 1; n < 400; n++) begin
      start = (n == 10 || n == 40 || n == 100);
      step();
    end
    start = 1'b0;
    check("busy_start_dones", done_cnt, 1);
    check("busy_start_idle", busy, 1'b0);

    // Start held high: back-to-back transfers separated by the IDLE and LOAD cycles.
    clear_counts();
    d1 = -1; d2 = -1; hi = 0; between = 1'b0;
    start = 1'b1;
    for (int n = 0; n < 400 && d2 < 0; n++) begin
      step();
      if (between) begin
        if (ss_n) hi++;
        else if (hi > 0) between = 1'b0;
      end
      if (done) begin
        if (d1 < 0) begin
          d1 = n; between = 1'b1;
        end else begin
          d2 = n;
        end
      end
    end
    start = 1'b0;
    check("b2b_done_gap", d2 - d1, DoneU + 2);
    check("b2b_ss_n_high", hi, 2);
    for (int n = 0; n < 10; n++) step();

    // Randomized start/reset/mode traffic against the timing model.
    for (int n = 0; n < 4000; n++) begin
      start      = ($urandom_range(0, 7) == 0);
      rst        = ($urandom_range(0, 599) == 0);
      cpol       = $urandom_range(0, 1);
      cpha       = $urandom_range(0, 1);
      tx_word    = 16'($urandom);
      slave_word = 16'($urandom);
      step();
    end
    rst = 1'b0; start = 1'b0;
    for (int n = 0; n < 300; n++) step();
    check("final_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
